// File: rtl/keccak_msg_feeder_pkg.sv
// Shared definitions for the keccak256 message feeder: word geometry and FSM state encodings.
`default_nettype none

package keccak_msg_feeder_pkg;

   localparam int WORD_W         = 32;
   localparam int BYTE_W         = 8;
   localparam int BYTE_NUM_W     = 2;
   localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_FILL = 3'd2,
      ST_SEND = 3'd3,
      ST_PAD  = 3'd4,
      ST_WAIT = 3'd5,
      ST_DONE = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/keccak_msg_feeder_packer.sv
// Packs bytes big-endian into a 32-bit word; the presented word already contains the
// incoming byte, and bytes beyond it are zero.
`default_nettype none

module keccak_msg_feeder_packer
   import keccak_msg_feeder_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  clear,
   input  logic                  push,
   input  logic [BYTE_W-1:0]     data,
   input  logic                  last,
   output logic [WORD_W-1:0]     word,
   output logic                  word_done,
   output logic [BYTE_NUM_W-1:0] count
);

   logic [WORD_W-1:0]     word_q;
   logic [BYTE_NUM_W-1:0] count_q;

   always_comb begin
      word = word_q;
      for (int i = 0; i < BYTES_PER_WORD; i++) begin
         if (count_q == BYTE_NUM_W'(i))
            word[WORD_W-1-BYTE_W*i -: BYTE_W] = data;
      end
   end

   assign word_done = push & (last | (count_q == BYTE_NUM_W'(BYTES_PER_WORD - 1)));
   assign count     = count_q;

   // The buffer is zeroed on every completed word so short last words are zero-filled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         word_q  <= '0;
         count_q <= '0;
      end else if (clear || word_done) begin
         word_q  <= '0;
         count_q <= '0;
      end else if (push) begin
         word_q  <= word;
         count_q <= count_q + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/keccak_msg_feeder.sv
// Byte-stream front end for keccak256: resets the core, streams big-endian words with
// is_last/byte_num framing under buffer_full back-pressure, then captures and holds the digest.
`default_nettype none

module keccak_msg_feeder
   import keccak_msg_feeder_pkg::*;
#(
   parameter int DIGEST_W   = 256,
   parameter int RST_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [BYTE_W-1:0]     s_byte,
   input  logic                  s_valid,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  k_reset,
   output logic [WORD_W-1:0]     k_in,
   output logic                  k_in_ready,
   output logic                  k_is_last,
   output logic [BYTE_NUM_W-1:0] k_byte_num,
   input  logic                  k_buffer_full,
   input  logic [DIGEST_W-1:0]   k_out,
   input  logic                  k_out_ready,
   output logic [DIGEST_W-1:0]   digest,
   output logic                  digest_valid,
   input  logic                  digest_ack,
   output logic                  busy
);

   localparam logic [3:0] CLR_LAST = 4'(RST_CYCLES - 1);

   state_t                state;
   logic [3:0]            clr_cnt;
   logic                  pad_pending;
   logic                  push;
   logic                  transfer;
   logic [WORD_W-1:0]     packed_word;
   logic                  word_done;
   logic [BYTE_NUM_W-1:0] fill_cnt;

   assign s_ready  = (state == ST_FILL);
   assign push     = s_valid & s_ready;
   assign transfer = k_in_ready & ~k_buffer_full;

   keccak_msg_feeder_packer u_packer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (state == ST_CLR),
      .push      (push),
      .data      (s_byte),
      .last      (s_last),
      .word      (packed_word),
      .word_done (word_done),
      .count     (fill_cnt)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         k_reset      <= 1'b1;
         clr_cnt      <= '0;
         pad_pending  <= 1'b0;
         k_in         <= '0;
         k_in_ready   <= 1'b0;
         k_is_last    <= 1'b0;
         k_byte_num   <= '0;
         digest       <= '0;
         digest_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               k_reset <= 1'b0;
               if (s_valid) begin
                  state   <= ST_CLR;
                  k_reset <= 1'b1;
                  clr_cnt <= '0;
                  busy    <= 1'b1;
               end
            end
            ST_CLR: begin
               if (clr_cnt == CLR_LAST) begin
                  k_reset <= 1'b0;
                  state   <= ST_FILL;
               end else begin
                  clr_cnt <= clr_cnt + 4'd1;
               end
            end
            ST_FILL: begin
               if (word_done) begin
                  k_in       <= packed_word;
                  k_in_ready <= 1'b1;
                  state      <= ST_SEND;
                  k_is_last  <= 1'b0;
                  k_byte_num <= '0;
                  // A full final word cannot carry byte_num=4, so an empty last word follows it.
                  if (s_last) begin
                     if (fill_cnt == BYTE_NUM_W'(BYTES_PER_WORD - 1)) begin
                        pad_pending <= 1'b1;
                     end else begin
                        k_is_last  <= 1'b1;
                        k_byte_num <= fill_cnt + 1'b1;
                     end
                  end
               end
            end
            ST_SEND: begin
               if (transfer) begin
                  if (pad_pending) begin
                     state       <= ST_PAD;
                     pad_pending <= 1'b0;
                     k_in        <= '0;
                     k_is_last   <= 1'b1;
                     k_byte_num  <= '0;
                  end else if (k_is_last) begin
                     state      <= ST_WAIT;
                     k_in_ready <= 1'b0;
                     k_is_last  <= 1'b0;
                     k_byte_num <= '0;
                  end else begin
                     state      <= ST_FILL;
                     k_in_ready <= 1'b0;
                  end
               end
            end
            ST_PAD: begin
               if (transfer) begin
                  state      <= ST_WAIT;
                  k_in_ready <= 1'b0;
                  k_is_last  <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (k_out_ready) begin
                  digest       <= k_out;
                  digest_valid <= 1'b1;
                  state        <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (digest_ack) begin
                  digest_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
